// File: rtl/tile_join_model_if.sv
// tile_join_model_if: join-tile stream bundle (N_IN input streams, one output stream, counters and status).
interface tile_join_model_if #(
  parameter int DW = 32,
  parameter int N_IN = 3
);
  logic [N_IN*DW-1:0] in_data_i;
  logic [N_IN-1:0]    in_valid_i;
  logic [N_IN-1:0]    in_ready_o;
  logic [DW-1:0]      out_data_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [N_IN*32-1:0] in_cnt_o;
  logic [31:0]        out_cnt_o;
  logic               started_o;
  logic               done_o;
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, in_cnt_o, out_cnt_o, started_o, done_o
  );
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, in_cnt_o, out_cnt_o, started_o, done_o
  );
endinterface

// File: rtl/tile_join_model.sv
// tile_join_model: dependency-only tile; joins N_IN FWFT-buffered streams into a LATENCY-deep elastic pipeline and counts flits.
module tile_join_model #(
  parameter int DW = 32,
  parameter int N_IN = 3,
  parameter int DEPTH_LOG = 2,
  parameter int LATENCY = 2,
  parameter int DATA_SEL = 0,
  parameter int PKT_TOTAL = 1000,
  parameter int X = 0,
  parameter int Y = 0
) (
  input logic clk_i,
  input logic rst_i,
  tile_join_model_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int CW = DEPTH_LOG + 1;
  localparam int LMAX = LATENCY > 0 ? LATENCY : 1;
  logic [DW-1:0]        mem_q [N_IN][DEPTH];
  logic [DEPTH_LOG-1:0] wptr_q [N_IN], wptr_d [N_IN], rptr_q [N_IN], rptr_d [N_IN];
  logic [CW-1:0]        cnt_q [N_IN], cnt_d [N_IN];
  logic [31:0]          in_cnt_q [N_IN], in_cnt_d [N_IN];
  logic [31:0]          out_cnt_q, out_cnt_d;
  logic [N_IN-1:0]      wr, full, empty, fresh_q;
  logic [LATENCY:0]     acc;
  logic [LMAX-1:0]      pv_q, pv_d;
  logic [LMAX-1:0][DW-1:0] pd_q, pd_d;
  logic [DW-1:0]        head, out_d;
  logic                 join_v, join_fire, out_v, out_hs;
  logic                 started_q, started_d, done_q, done_d;
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      full[i] = cnt_q[i][DEPTH_LOG];
      // a flit written on the previous edge is not yet joinable
      empty[i] = (cnt_q[i] - CW'(fresh_q[i])) == '0;
      wr[i] = bus.in_valid_i[i] & ~full[i];
    end
    join_v = &(~empty);
    head = mem_q[DATA_SEL][rptr_q[DATA_SEL]];
    acc[LATENCY] = bus.out_ready_i;
    for (int k = LATENCY - 1; k >= 0; k--) acc[k] = ~pv_q[k] | acc[k+1];
    join_fire = join_v & acc[0];
    pv_d = pv_q;
    pd_d = pd_q;
    if (LATENCY > 0 && acc[0]) begin
      pv_d[0] = join_fire;
      pd_d[0] = join_fire ? head : pd_q[0];
    end
    for (int k = 1; k < LATENCY; k++)
      if (acc[k]) begin
        pv_d[k] = pv_q[k-1];
        pd_d[k] = pv_q[k-1] ? pd_q[k-1] : pd_q[k];
      end
    out_v = LATENCY == 0 ? join_v : pv_q[LMAX-1];
    out_d = LATENCY == 0 ? (join_v ? head : '0) : pd_q[LMAX-1];
    out_hs = out_v & bus.out_ready_i;
    for (int i = 0; i < N_IN; i++) begin
      wptr_d[i] = wptr_q[i] + DEPTH_LOG'(wr[i]);
      rptr_d[i] = rptr_q[i] + DEPTH_LOG'(join_fire);
      cnt_d[i] = cnt_q[i] + CW'(wr[i]) - CW'(join_fire);
      in_cnt_d[i] = in_cnt_q[i] + 32'(wr[i] & ~&in_cnt_q[i]);
    end
    out_cnt_d = out_cnt_q + 32'(out_hs & ~&out_cnt_q);
    started_d = started_q | join_fire;
    done_d = done_q | (out_hs && out_cnt_d == 32'(PKT_TOTAL));
  end
  always_comb begin
    bus.in_cnt_o = '0;
    for (int i = 0; i < N_IN; i++) bus.in_cnt_o[i*32 +: 32] = in_cnt_q[i];
  end
  assign bus.in_ready_o  = ~full;
  assign bus.out_valid_o = out_v;
  assign bus.out_data_o  = out_d;
  assign bus.out_cnt_o   = out_cnt_q;
  assign bus.started_o   = started_q;
  assign bus.done_o      = done_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i] <= '0;
        in_cnt_q[i] <= '0;
      end
      fresh_q <= '0;
      pv_q <= '0;
      pd_q <= '0;
      out_cnt_q <= '0;
      started_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i] <= cnt_d[i];
        in_cnt_q[i] <= in_cnt_d[i];
      end
      fresh_q <= wr;
      pv_q <= pv_d;
      pd_q <= pd_d;
      out_cnt_q <= out_cnt_d;
      started_q <= started_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_IN; i++)
      if (wr[i]) mem_q[i][wptr_q[i]] <= bus.in_data_i[i*DW +: DW];
  end
`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && join_fire && !started_q)
      $display("time %0t: node (%0d, %0d) starting computing ...", $time, X, Y);
    if (!rst_i && done_d && !done_q)
      $display("time %0t: node (%0d, %0d) finished computing ...", $time, X, Y);
  end
`endif
endmodule
